mem_stage: RTL and testbench
============================

# mem_stage

Memory stage of the five-stage pipelined RISC-V core, directly downstream of the Execute→Memory control/data register. It takes the M-stage control and data, performs loads and stores over a single-outstanding valid/ready data bus with byte-lane formatting, and stalls the front of the pipeline while an access is in flight. It also owns the Memory→Writeback register and delivers the W-stage values, including extended load data and a fault code.

## Interface
- `TIMEOUT`, default 255: maximum REQ cycles before an access is aborted. Range 1–255.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `RegWriteM` in 1: M-stage register-write enable.
- `ResultSrcM` in 2: 00 ALU, 01 load data, 10 PC+4. The value 01 marks a load.
- `MemWriteM` in 1: store.
- `funct3M` in 3: access size and sign. 000 b, 001 h, 010 w, 100 bu, 101 hu.
- `ALUResultM` in 32: effective address or ALU result.
- `WriteDataM` in 32: store data (rs2).
- `RdM` in 5: destination register.
- `PCPlus4M` in 32: PC+4.
- `mem_req` out 1: bus request, registered.
- `mem_we` out 1: 1 for store.
- `mem_addr` out 32: word address. Low two bits are 00.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_wstrb` out 4: byte enables. 0000 on loads.
- `mem_ready` in 1: access complete this cycle.
- `mem_rdata` in 32: read word. Valid when `mem_ready`=1 on a load.
- `StallM` out 1: freeze F/D/E stages and the E→M register.
- `RegWriteW` out 1: W-stage outputs, registered.
- `ResultSrcW` out 2.
- `ALUResultW` out 32.
- `ReadDataW` out 32.
- `RdW` out 5.
- `PCPlus4W` out 32.
- `FaultW` out 2: 00 none, 01 misaligned or bad funct3, 10 bus timeout.

## Operation
- An access is present when `ResultSrcM`=01 or `MemWriteM`=1. If both are set, it is treated as a store.
- Misalignment rules:
  - h/hu: addr[0]≠0 is misaligned.
  - w: addr[1:0]≠00 is misaligned.
  - Load funct3 011/110/111 and store funct3 ≥011 are faults.
- Non-access or faulting instructions:
  - No bus activity and no stall.
  - W loads the M values in one cycle.
  - On a fault, W loads with `RegWriteW`=0 and `FaultW`=01.
- State machine: IDLE, REQ, RESP.
  - IDLE with a valid access: `StallM`=1. Address, byte-lane data, strobes and funct3 are latched, and the state goes to REQ. W loads a bubble (RegWriteW=0, FaultW=00, other fields don't-care).
  - REQ: `mem_req`=1, with `mem_we`, `mem_addr`, `mem_wdata` and `mem_wstrb` stable from the latch. `StallM`=1 and W loads a bubble. On `mem_ready`=1, `mem_rdata` is captured and the state goes to RESP. With no ready, the timeout counter increments. If the counter equals `TIMEOUT`-1 and `mem_ready`=0, the access is aborted and the state goes to RESP with a timeout flag.
  - RESP: `StallM`=0 and `mem_req`=0. W loads the M instruction with the extended load data. If the timeout flag is set, it loads `RegWriteW`=0 and `FaultW`=10. Next state is IDLE.
- Store formatting:
  - sb: wstrb=0001<<addr[1:0], wdata={4{rs2[7:0]}}.
  - sh: wstrb=addr[1]?1100:0011, wdata={2{rs2[15:0]}}.
  - sw: wstrb=1111, wdata=rs2.
- Load extraction selects the byte or halfword by addr[1:0] and applies per-funct3 extension: sign for b/h, zero for bu/hu.
- Neighbouring stages must hold all M inputs stable while `StallM`=1.

## Timing
- Reset values: all W outputs 0, `FaultW`=00, `mem_req`=0, `mem_we`=0, `mem_wstrb`=0000, `mem_addr`=0, `mem_wdata`=0, state IDLE, counter 0. `StallM` is forced to 0 while `reset` is high.
- Non-access latency: 1 cycle from M to W.
- Access latency: 2+N cycles in M, where N is the number of REQ cycles (N≥1). With zero wait states, `StallM` is high for 2 cycles.
- Ready arriving on the final permitted REQ cycle wins over the timeout.
- Reset during REQ drops `mem_req` immediately, asynchronously. The bus agent must tolerate an abandoned request.
- `mem_ready` outside REQ is ignored.

## Test plan
- ALU instruction: RegWriteM=1, ResultSrcM=00, ALUResultM=0x1234, RdM=5 → next cycle RegWriteW=1, ALUResultW=0x1234, RdW=5, StallM never 1.
- lb at 0x103 with mem_rdata=0x80FF_0000 and ready on the first REQ cycle → StallM high for 2 cycles, mem_addr=0x100, mem_wstrb=0000, ReadDataW=0xFFFF_FF80.
- sh at 0x202 with rs2=0xABCD1234 and ready after 3 wait cycles → mem_wstrb=1100, mem_wdata=0x12341234, mem_we=1, StallM high for 5 cycles, RegWriteW=0.
- lw at 0x301 → no mem_req, StallM=0, next cycle RegWriteW=0, FaultW=01.
- TIMEOUT=4 with mem_ready held low on a load → mem_req high for exactly 4 cycles, then FaultW=10 and RegWriteW=0.
- Reset asserted on the second REQ cycle → mem_req, StallM and W outputs go to 0 immediately. After release, state is IDLE and the next ALU instruction flows with 1-cycle latency.

Source files
------------

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - RISC-V memory stage: bus access FSM, byte-lane formatting, M->W register
// Single-outstanding load/store master that stalls the front end while an access is in flight.
module mem_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic        MemWriteM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [4:0]  RdM,
  input  logic [31:0] PCPlus4M,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        StallM,
  output logic        RegWriteW,
  output logic [1:0]  ResultSrcW,
  output logic [31:0] ALUResultW,
  output logic [31:0] ReadDataW,
  output logic [4:0]  RdW,
  output logic [31:0] PCPlus4W,
  output logic [1:0]  FaultW
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  localparam logic [7:0] LAST_REQ = 8'(TIMEOUT - 1);

  state_t      state, stateNext;
  logic [7:0]  reqCount;
  logic        timedOut;
  logic [31:0] rdataQ;
  logic [2:0]  funct3Q;
  logic [1:0]  offsetQ;

  logic        isStore, isLoad, isAccess, badFunct3, misaligned, accFault, accGo;
  logic [3:0]  stWstrb;
  logic [31:0] stWdata;
  logic        stall, wRegWrite;
  logic [1:0]  wFault;
  logic [31:0] loadShifted, loadExt;
  logic [7:0]  loadByte;
  logic [15:0] loadHalf;

  // A set MemWriteM takes precedence, so a load is only ResultSrcM=01 without a store.
  assign isStore    = MemWriteM;
  assign isLoad     = (ResultSrcM == 2'b01) && !MemWriteM;
  assign isAccess   = isStore || isLoad;
  assign badFunct3  = isStore ? (funct3M >= 3'b011)
                              : ((funct3M == 3'b011) || (funct3M[2:1] == 2'b11));
  assign misaligned = ((funct3M[1:0] == 2'b01) && ALUResultM[0]) ||
                      ((funct3M[1:0] == 2'b10) && (ALUResultM[1:0] != 2'b00));
  assign accFault   = isAccess && (badFunct3 || misaligned);
  assign accGo      = isAccess && !accFault;

  always_comb begin
    stWstrb = 4'b1111;
    stWdata = WriteDataM;
    case (funct3M[1:0])
      2'b00: begin
        stWstrb = 4'b0001 << ALUResultM[1:0];
        stWdata = {4{WriteDataM[7:0]}};
      end
      2'b01: begin
        stWstrb = ALUResultM[1] ? 4'b1100 : 4'b0011;
        stWdata = {2{WriteDataM[15:0]}};
      end
      default: ;
    endcase
  end

  assign loadShifted = rdataQ >> {offsetQ, 3'b000};
  assign loadByte    = loadShifted[7:0];
  assign loadHalf    = offsetQ[1] ? rdataQ[31:16] : rdataQ[15:0];

  always_comb begin
    case (funct3Q)
      3'b000:  loadExt = {{24{loadByte[7]}}, loadByte};
      3'b100:  loadExt = {24'd0, loadByte};
      3'b001:  loadExt = {{16{loadHalf[15]}}, loadHalf};
      3'b101:  loadExt = {16'd0, loadHalf};
      default: loadExt = rdataQ;
    endcase
  end

  always_comb begin
    stateNext = state;
    stall     = 1'b0;
    wRegWrite = 1'b0;
    wFault    = 2'b00;
    case (state)
      IDLE: begin
        if (accGo) begin
          stall     = 1'b1;
          stateNext = REQ;
        end else begin
          wRegWrite = accFault ? 1'b0 : RegWriteM;
          wFault    = accFault ? 2'b01 : 2'b00;
        end
      end
      REQ: begin
        stall = 1'b1;
        // Ready on the last permitted cycle wins over the abort.
        if (mem_ready || (reqCount == LAST_REQ)) stateNext = RESP;
      end
      RESP: begin
        stateNext = IDLE;
        wRegWrite = timedOut ? 1'b0 : RegWriteM;
        wFault    = timedOut ? 2'b10 : 2'b00;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign StallM = stall && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      reqCount   <= 8'd0;
      timedOut   <= 1'b0;
      rdataQ     <= 32'd0;
      funct3Q    <= 3'd0;
      offsetQ    <= 2'd0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
      mem_wstrb  <= 4'd0;
      RegWriteW  <= 1'b0;
      ResultSrcW <= 2'd0;
      ALUResultW <= 32'd0;
      ReadDataW  <= 32'd0;
      RdW        <= 5'd0;
      PCPlus4W   <= 32'd0;
      FaultW     <= 2'd0;
    end else begin
      state   <= stateNext;
      mem_req <= (stateNext == REQ);
      if (state == IDLE && accGo) begin
        mem_we    <= isStore;
        mem_addr  <= {ALUResultM[31:2], 2'b00};
        mem_wdata <= isStore ? stWdata : 32'd0;
        mem_wstrb <= isStore ? stWstrb : 4'b0000;
        funct3Q   <= funct3M;
        offsetQ   <= ALUResultM[1:0];
        reqCount  <= 8'd0;
        timedOut  <= 1'b0;
      end
      if (state == REQ) begin
        if (mem_ready) rdataQ <= mem_rdata;
        else if (reqCount == LAST_REQ) timedOut <= 1'b1;
        else reqCount <= reqCount + 8'd1;
      end
      // Bubbles only need RegWriteW/FaultW cleared; the remaining fields follow M.
      RegWriteW  <= wRegWrite;
      FaultW     <= wFault;
      ResultSrcW <= ResultSrcM;
      ALUResultW <= ALUResultM;
      ReadDataW  <= loadExt;
      RdW        <= RdM;
      PCPlus4W   <= PCPlus4M;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage
// Directed test-plan cases followed by random instructions against an arithmetic reference model.
module tb_mem_stage;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  funct3M;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RdM;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        StallM, RegWriteW;
  logic [1:0]  ResultSrcW, FaultW;
  logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
  logic [4:0]  RdW;

  int nVec = 0;
  int nErr = 0;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
    .funct3M(funct3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .RdM(RdM), .PCPlus4M(PCPlus4M),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .StallM(StallM), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
    .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .RdW(RdW),
    .PCPlus4W(PCPlus4W), .FaultW(FaultW)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] expLoad(input logic [2:0] f3, input logic [31:0] addr,
                                          input logic [31:0] word);
    int     bytes = 1 << f3[1:0];
    longint bits  = 8 * bytes;
    longint v;
    v = (longint'(word) >> (8 * (addr % 4))) & ((64'd1 << bits) - 1);
    if (!f3[2] && bytes < 4 && v >= (64'd1 << (bits - 1))) v = v - (64'd1 << bits);
    return v[31:0];
  endfunction

  // Called just after a rising edge; returns just after the edge that loads W.
  task automatic runInstr(input logic rw, input logic [1:0] rs, input logic mw,
                          input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] rs2, input logic [4:0] rd,
                          input logic [31:0] pc4, input int waits, input logic [31:0] rdata);
    bit isSt  = mw;
    bit isLd  = !mw && (rs == 2'b01);
    bit acc   = isSt || isLd;
    int bytes = 1 << f3[1:0];
    bit bad   = isSt ? (f3 >= 3) : (f3 == 3 || f3 >= 6);
    bit fault = acc && (bad || (int'(addr[2:0]) % bytes) != 0);
    bit go    = acc && !fault;
    bit tmo   = go && (waits + 1 > TMO);
    int nReq  = !go ? 0 : (tmo ? TMO : waits + 1);
    logic [1:0]  expFault = fault ? 2'b01 : (tmo ? 2'b10 : 2'b00);
    logic [3:0]  expStrb  = isSt ? 4'(((1 << bytes) - 1) << (addr % 4)) : 4'b0000;
    logic [31:0] expWdata;
    int stallCnt = 0;
    int reqCnt   = 0;
    bit done     = 0;
    if (!isSt) expWdata = 32'd0;
    else if (bytes == 1) expWdata = rs2[7:0] * 32'h0101_0101;
    else if (bytes == 2) expWdata = rs2[15:0] * 32'h0001_0001;
    else expWdata = rs2;

    RegWriteM = rw; ResultSrcM = rs; MemWriteM = mw; funct3M = f3;
    ALUResultM = addr; WriteDataM = rs2; RdM = rd; PCPlus4M = pc4;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clk);
      if (StallM) stallCnt++;
      if (mem_req) begin
        reqCnt++;
        if (reqCnt == 1) begin
          chk("bus_addr", mem_addr, {addr[31:2], 2'b00});
          chk("bus_we", 32'(mem_we), 32'(isSt));
          chk("bus_wstrb", 32'(mem_wstrb), 32'(expStrb));
          if (isSt) chk("bus_wdata", mem_wdata, expWdata);
        end
        mem_ready = (reqCnt == waits + 1);
        mem_rdata = (reqCnt == waits + 1) ? rdata : $urandom;
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
      end
      if (!StallM) done = 1;
      @(posedge clk);
      #1;
    end
    mem_ready = 1'b0;
    chk("finished", 32'(done), 32'd1);
    chk("stall_cycles", stallCnt, go ? nReq + 1 : 0);
    chk("req_cycles", reqCnt, nReq);
    chk("RegWriteW", 32'(RegWriteW), (expFault == 2'b00) ? 32'(rw) : 32'd0);
    chk("FaultW", 32'(FaultW), 32'(expFault));
    chk("RdW", 32'(RdW), 32'(rd));
    chk("ALUResultW", ALUResultW, addr);
    chk("PCPlus4W", PCPlus4W, pc4);
    chk("ResultSrcW", 32'(ResultSrcW), 32'(rs));
    if (isLd && go && !tmo) chk("ReadDataW", ReadDataW, expLoad(f3, addr, rdata));
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b0; mem_rdata = 32'd0;
    RegWriteM = 1'b1; ResultSrcM = 2'b01; MemWriteM = 1'b0; funct3M = 3'b010;
    ALUResultM = 32'h40; WriteDataM = 32'd0; RdM = 5'd1; PCPlus4M = 32'h4;
    @(negedge clk);
    chk("rst_StallM", 32'(StallM), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_wstrb", 32'(mem_wstrb), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_RegWriteW", 32'(RegWriteW), 32'd0);
    chk("rst_FaultW", 32'(FaultW), 32'd0);
    chk("rst_ALUResultW", ALUResultW, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    runInstr(1'b1, 2'b00, 1'b0, 3'b000, 32'h1234, 32'h0, 5'd5, 32'h100, 0, 32'h0);
    runInstr(1'b1, 2'b01, 1'b0, 3'b000, 32'h103, 32'h0, 5'd6, 32'h104, 0, 32'h80FF_0000);
    runInstr(1'b0, 2'b00, 1'b1, 3'b001, 32'h202, 32'hABCD_1234, 5'd0, 32'h108, 3, 32'h0);
    runInstr(1'b1, 2'b01, 1'b0, 3'b010, 32'h301, 32'h0, 5'd7, 32'h10C, 0, 32'h0);
    runInstr(1'b1, 2'b01, 1'b0, 3'b010, 32'h400, 32'h0, 5'd8, 32'h110, 20, 32'h0);

    // Reset on the second REQ cycle of a load
    RegWriteM = 1'b1; ResultSrcM = 2'b01; MemWriteM = 1'b0; funct3M = 3'b010;
    ALUResultM = 32'h500; RdM = 5'd9; PCPlus4M = 32'h114; mem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_req", 32'(mem_req), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_req", 32'(mem_req), 32'd0);
    chk("mid_rst_StallM", 32'(StallM), 32'd0);
    chk("mid_rst_RegWriteW", 32'(RegWriteW), 32'd0);
    chk("mid_rst_ALUResultW", ALUResultW, 32'd0);
    chk("mid_rst_PCPlus4W", PCPlus4W, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    runInstr(1'b1, 2'b10, 1'b0, 3'b000, 32'h5555, 32'h0, 5'd10, 32'h118, 0, 32'h0);

    for (int i = 0; i < 40; i++) begin
      logic mw = 1'($urandom_range(0, 2) == 0);
      logic [1:0] rs = 2'($urandom_range(0, 2));
      logic [31:0] a = $urandom & 32'h0000_0FFF;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      runInstr(1'($urandom), rs, mw, 3'($urandom), a, $urandom, 5'($urandom),
               $urandom, int'($urandom_range(0, 5)), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end
endmodule
